// File: rtl/busy_stall_gen.sv
// Stall-pattern generator for the SoC busy input: LFSR-drawn hold segments with saturating perf counters.
// Optional BSG_SEED_LOAD_EN adds seed_load/seed_in for reseeding the LFSR at run time.
module busy_stall_gen #(
    parameter int unsigned       LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
    parameter int unsigned       HOLD_MIN = 5,
    parameter int unsigned       HOLD_MAX = 10,
    parameter int unsigned       CNT_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [6:0]        prob_pct,
    input  logic              clr_stats,
`ifdef BSG_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
`endif
    output logic              busy,
    output logic              seg_done,
    output logic [CNT_W-1:0]  busy_cycles,
    output logic [CNT_W-1:0]  total_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_HOLD
    } state_t;

    localparam logic [LFSR_W-1:0] POLY_MASK = LFSR_W'(16'hB400);
    // An all-zero Galois LFSR never leaves zero, so a zero seed becomes 1.
    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam int unsigned       HOLD_SPAN = HOLD_MAX - HOLD_MIN + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic              busy_q, busy_d;
    logic              seg_done_q, seg_done_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic [CNT_W-1:0]  total_cnt_q, total_cnt_d;
    logic [6:0]        pct_draw;
    logic [7:0]        hold_len;

    // Both draws come from the LFSR value that DRAW is about to commit.
    always_comb begin
        lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY_MASK : '0);
        pct_draw  = 7'((14'(lfsr_step[6:0]) * 14'd100) >> 7);
        hold_len  = 8'(HOLD_MIN) + 8'(32'(lfsr_step[15:8]) % HOLD_SPAN);
    end

    always_comb begin
        // NOTE: every _d signal gets a default first, so no path through this block can infer a latch.
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        hold_cnt_d = hold_cnt_q;
        busy_d     = busy_q;
        seg_done_d = 1'b0;

        if (!en) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            hold_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DRAW;
                    busy_d  = 1'b0;
                end
                ST_DRAW: begin
                    lfsr_d     = lfsr_step;
                    busy_d     = (pct_draw < prob_pct);
                    hold_cnt_d = hold_len - 8'd1;
                    seg_done_d = (hold_len == 8'd1);
                    state_d    = ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_d = ST_DRAW;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                        // seg_done is registered, so it is raised on the edge entering the last HOLD cycle.
                        seg_done_d = (hold_cnt_q == 8'd1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    hold_cnt_d = 8'd0;
                end
            endcase
        end

`ifdef BSG_SEED_LOAD_EN
        if (seed_load) begin
            lfsr_d     = (seed_in == '0) ? LFSR_W'(1) : seed_in;
            state_d    = ST_DRAW;
            busy_d     = 1'b0;
            hold_cnt_d = 8'd0;
            seg_done_d = 1'b0;
        end
`endif

        busy_cnt_d  = busy_cnt_q;
        total_cnt_d = total_cnt_q;
        if (clr_stats) begin
            busy_cnt_d  = '0;
            total_cnt_d = '0;
        end else if (en) begin
            if (total_cnt_q != '1) total_cnt_d = total_cnt_q + CNT_ONE;
            if (busy_q && (busy_cnt_q != '1)) busy_cnt_d = busy_cnt_q + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED_SAFE;
            hold_cnt_q  <= 8'd0;
            busy_q      <= 1'b0;
            seg_done_q  <= 1'b0;
            busy_cnt_q  <= '0;
            total_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            hold_cnt_q  <= hold_cnt_d;
            busy_q      <= busy_d;
            seg_done_q  <= seg_done_d;
            busy_cnt_q  <= busy_cnt_d;
            total_cnt_q <= total_cnt_d;
        end
    end

    assign busy         = busy_q;
    assign seg_done     = seg_done_q;
    assign busy_cycles  = busy_cnt_q;
    assign total_cycles = total_cnt_q;

endmodule

// File: tb/tb_busy_stall_gen.sv
// Self-checking bench for busy_stall_gen: a queue-based segment schedule model checked every cycle,
// plus directed phases with hand-computed expectations (define BSG_SEED_LOAD_EN to cover seed loading).
`timescale 1ns/1ps
module tb_busy_stall_gen;

    localparam logic [15:0] POLY = 16'hB400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr_stats = 1'b0;
    logic        seed_load = 1'b0;
    logic [6:0]  prob_pct = 7'd0;
    logic [15:0] seed_in = 16'h0;
    logic        busy, seg_done, busy4, seg_done4;
    logic [63:0] busy_cycles, total_cycles;
    logic [3:0]  busy_cycles4, total_cycles4;

    int n_cmp = 0;
    int n_mis = 0;

    busy_stall_gen dut (
        .clk(clk), .rst(rst), .en(en), .prob_pct(prob_pct), .clr_stats(clr_stats),
`ifdef BSG_SEED_LOAD_EN
        .seed_load(seed_load), .seed_in(seed_in),
`endif
        .busy(busy), .seg_done(seg_done), .busy_cycles(busy_cycles), .total_cycles(total_cycles)
    );

    busy_stall_gen #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .prob_pct(prob_pct), .clr_stats(clr_stats),
`ifdef BSG_SEED_LOAD_EN
        .seed_load(seed_load), .seed_in(seed_in),
`endif
        .busy(busy4), .seg_done(seg_done4), .busy_cycles(busy_cycles4), .total_cycles(total_cycles4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction
    function automatic int pct_of(input logic [15:0] v);
        return (int'(v[6:0]) * 100) / 128;
    endfunction
    function automatic int len_of(input logic [15:0] v);
        return 5 + (int'(v[15:8]) % 6);
    endfunction

    // Model: a schedule of per-cycle output entries; a segment is drawn whenever the DRAW entry is current.
    typedef struct packed { logic b; logic s; logic d; } ent_t;
    ent_t        sched[$];
    ent_t        cur;
    bit          m_idle;
    logic [15:0] m_lfsr;
    logic [63:0] m_busy, m_total;
    int          m_busy4, m_total4;

    task automatic model_reset();
        sched.delete();
        cur      = '{b: 1'b0, s: 1'b0, d: 1'b0};
        m_idle   = 1'b1;
        m_lfsr   = 16'hACE1;
        m_busy   = 64'd0;
        m_total  = 64'd0;
        m_busy4  = 0;
        m_total4 = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        int   len;
        if (clr_stats) begin
            m_busy = 64'd0; m_total = 64'd0; m_busy4 = 0; m_total4 = 0;
        end else if (en) begin
            if (m_total != '1) m_total = m_total + 64'd1;
            if (cur.b && (m_busy != '1)) m_busy = m_busy + 64'd1;
            if (m_total4 < 15) m_total4++;
            if (cur.b && (m_busy4 < 15)) m_busy4++;
        end
        if (seed_load) begin
            m_lfsr = (seed_in == 16'h0) ? 16'h0001 : seed_in;
            sched.delete();
            cur    = '{b: 1'b0, s: 1'b0, d: 1'b1};
            m_idle = 1'b0;
        end else if (!en) begin
            sched.delete();
            cur    = '{b: 1'b0, s: 1'b0, d: 1'b0};
            m_idle = 1'b1;
        end else if (m_idle) begin
            cur    = '{b: 1'b0, s: 1'b0, d: 1'b1};
            m_idle = 1'b0;
        end else if (cur.d) begin
            m_lfsr = lfsr_next(m_lfsr);
            len    = len_of(m_lfsr);
            e.b    = (pct_of(m_lfsr) < int'(prob_pct));
            for (int i = 1; i <= len; i++) begin
                e.s = (i == len);
                e.d = 1'b0;
                sched.push_back(e);
            end
            e.s = 1'b0;
            e.d = 1'b1;
            sched.push_back(e);
            cur = sched.pop_front();
        end else begin
            cur = sched.pop_front();
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_edge();
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, cur.b);
            check("seg_done", seg_done, cur.s);
            check("busy_w4", busy4, cur.b);
            check("seg_done_w4", seg_done4, cur.s);
            check("busy_cycles", busy_cycles, m_busy);
            check("total_cycles", total_cycles, m_total);
            check("busy_cycles_w4", busy_cycles4, m_busy4);
            check("total_cycles_w4", total_cycles4, m_total4);
        end
    end

    task automatic do_reset();
        en = 1'b0; clr_stats = 1'b0; seed_load = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // From reset the first three draws are 0xE270 (87%, len 9), 0x7138 (43%, len 10), 0x389C (21%, len 7).
    task automatic pin_run(input string tag);
        int first_busy = -1;
        int sd1 = -1;
        int sd2 = -1;
        prob_pct = 7'd50;
        en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy && first_busy < 0) first_busy = i;
            if (seg_done) begin
                if (sd1 < 0) sd1 = i;
                else if (sd2 < 0) sd2 = i;
            end
        end
        en = 1'b0;
        check({tag, "_first_seg_done"}, sd1, 10);
        check({tag, "_first_busy"}, first_busy, 12);
        check({tag, "_second_seg_done"}, sd2, 21);
        @(negedge clk);
        check({tag, "_en_drop_busy"}, busy, 0);
        check({tag, "_busy_cycles"}, busy_cycles, 18);
        check({tag, "_total_cycles"}, total_cycles, 30);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   mn, mx, last, any_busy, first, bad, found, segs, busy_segs, cyc, bad_len, seen;
        int   hist [11];
        logic [1:0] rec [61];
        model_reset();

        check("model_step0", lfsr_next(16'hACE1), 16'hE270);
        check("model_pct0", pct_of(16'hE270), 87);
        check("model_len0", len_of(16'hE270), 9);
        check("model_step_seed1", lfsr_next(16'h0001), 16'hB400);

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_seg_done", seg_done, 0);
        check("rst_busy_cycles", busy_cycles, 0);
        check("rst_total_cycles", total_cycles, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        pin_run("first");

        // prob 0: never busy, segment spacing stays within HOLD_MIN+1..HOLD_MAX+1.
        do_reset();
        prob_pct = 7'd0; en = 1'b1;
        mn = 1000; mx = 0; last = -1; any_busy = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (busy) any_busy = 1;
            if (seg_done) begin
                if (last >= 0) begin
                    if (i - last < mn) mn = i - last;
                    if (i - last > mx) mx = i - last;
                end
                last = i;
            end
        end
        en = 1'b0;
        check("p0_busy_never", any_busy, 0);
        check("p0_spacing_min_ok", (mn >= 6), 1);
        check("p0_spacing_max_ok", (mx >= 6 && mx <= 11), 1);
        check("p0_busy_cycles", busy_cycles, 0);
        check("p0_total_cycles", total_cycles, 2000);

        // prob 100: busy from cycle 2 on, narrow counters saturate, then clear and resume.
        do_reset();
        prob_pct = 7'd100; en = 1'b1;
        first = -1; bad = 0;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (busy && first < 0) first = i;
            if (i >= 2 && !busy) bad++;
        end
        check("p100_first_busy", first, 2);
        check("p100_busy_gaps", bad, 0);
        check("p100_busy_cycles", busy_cycles, 498);
        check("p100_total_cycles", total_cycles, 500);
        check("p100_busy_sat_w4", busy_cycles4, 15);
        check("p100_total_sat_w4", total_cycles4, 15);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check("clr_busy_cycles", busy_cycles, 0);
        check("clr_total_cycles", total_cycles, 0);
        check("clr_busy_w4", busy_cycles4, 0);
        check("clr_total_w4", total_cycles4, 0);
        repeat (5) @(negedge clk);
        check("resume_busy_cycles", busy_cycles, 5);
        check("resume_total_cycles", total_cycles, 5);
        check("resume_busy_w4", busy_cycles4, 5);

        // Asynchronous reset in the middle of a busy HOLD, then a rerun identical to the first one.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (seg_done) found = 1;
        end
        check("wait_seg_done", found, 1);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1; en = 1'b0; prob_pct = 7'd50;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_seg_done", seg_done, 0);
        check("async_rst_busy_cycles", busy_cycles, 0);
        check("async_rst_total_cycles", total_cycles, 0);
        check("async_rst_total_w4", total_cycles4, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        pin_run("rerun");

        // prob 30 over 2000 segments: busy fraction and hold-length coverage.
        do_reset();
        prob_pct = 7'd30; en = 1'b1;
        segs = 0; busy_segs = 0; last = -1; cyc = 0; bad_len = 0;
        for (int k = 0; k < 11; k++) hist[k] = 0;
        while (segs < 2000 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (seg_done) begin
                if (last >= 0) begin
                    if (cyc - last - 1 >= 5 && cyc - last - 1 <= 10) hist[cyc - last - 1]++;
                    else bad_len++;
                end
                last = cyc;
                segs++;
                if (busy) busy_segs++;
            end
        end
        en = 1'b0;
        seen = 1;
        for (int k = 5; k <= 10; k++) if (hist[k] == 0) seen = 0;
        check("p30_segments", segs, 2000);
        check("p30_hold_len_range", bad_len, 0);
        check("p30_hold_len_all_seen", seen, 1);
        check("p30_busy_segs_in_25_35pct", (busy_segs >= 500 && busy_segs <= 700), 1);

        // Randomized traffic, checked cycle by cycle against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            prob_pct  = 7'($urandom_range(0, 127));
            clr_stats = ($urandom_range(0, 63) == 0);
`ifdef BSG_SEED_LOAD_EN
            seed_load = ($urandom_range(0, 79) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
`endif
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end
        en = 1'b0; clr_stats = 1'b0; seed_load = 1'b0;
        @(negedge clk);

`ifdef BSG_SEED_LOAD_EN
        do_reset();
        prob_pct = 7'd50; en = 1'b1;
        seed_in = 16'h1234; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        rec[1] = {busy, seg_done};
        for (int i = 2; i <= 60; i++) begin
            @(negedge clk);
            rec[i] = {busy, seg_done};
        end
        repeat (940) @(negedge clk);
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        bad = (rec[1] !== {busy, seg_done}) ? 1 : 0;
        for (int i = 2; i <= 60; i++) begin
            @(negedge clk);
            if (rec[i] !== {busy, seg_done}) bad++;
        end
        check("seed_1234_trace_repeat", bad, 0);

        seed_in = 16'h0; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("seed0_load_busy", busy, 0);
        found = -1;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) check("seed0_first_busy", busy, 1);
            if (seg_done && found < 0) found = i;
        end
        check("seed0_seg_done_at", found, 6);
        en = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
